// File: rtl/newperf_tg_pkg.sv
// Shared types, default widths and the saturating latency accumulator
// for the performance traffic generator.
package newperf_tg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tg_state_e;

    localparam int TG_ADDR_W = 48;
    localparam int TG_ID_W   = 4;
    localparam int TG_TS_W   = 32;
    localparam int TG_CNT_W  = 32;
    localparam int TG_LSUM_W = 64;

    function automatic logic [TG_LSUM_W-1:0] lat_sat_add(
        input logic [TG_LSUM_W-1:0] sum,
        input logic [TG_LSUM_W-1:0] lat
    );
        logic [TG_LSUM_W:0] full;
        full = {1'b0, sum} + {1'b0, lat};
        return full[TG_LSUM_W] ? {TG_LSUM_W{1'b1}} : full[TG_LSUM_W-1:0];
    endfunction

endpackage

// File: rtl/newperf_token_bucket.sv
// Token bucket rate limiter: a down-counting period timer adds one token per
// period (saturating at depth); each accepted request consumes one token.
module newperf_token_bucket
    import newperf_tg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] period,
    input  logic [7:0]  depth,
    input  logic        consume,
    output logic        avail
);

    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tok_q, tok_d;
    logic [7:0]  depth_eff;
    logic        add;
    logic        take;

    // A zero depth would stall the run forever, so it behaves as depth 1.
    assign depth_eff = (depth == 8'd0) ? 8'd1 : depth;
    assign add       = en && (period != 16'd0) && (cnt_q == 16'd0);
    assign take      = consume && (tok_q != 8'd0);
    assign avail     = (tok_q != 8'd0);

    always_comb begin
        cnt_d = cnt_q;
        tok_d = tok_q;
        if (load) begin
            cnt_d = period - 16'd1;
            tok_d = depth_eff;
        end else if (en) begin
            cnt_d = (cnt_q == 16'd0) ? (period - 16'd1) : (cnt_q - 16'd1);
            if (add && !take) begin
                if (tok_q < depth_eff) tok_d = tok_q + 8'd1;
            end else if (take && !add) begin
                tok_d = tok_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tok_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tok_q <= tok_d;
        end
    end

endmodule

// File: rtl/newperf_traffic_gen.sv
// Rate-limited tagged request injector with out-of-order response retirement
// and per-run issue/complete/latency statistics.
//  state | meaning
//  IDLE  | after reset, waiting for cfg_start
//  RUN   | issuing requests, token bucket running
//  DRAIN | all requests issued, waiting for outstanding responses
//  DONE  | run finished, stats held until the next cfg_start
module newperf_traffic_gen
    import newperf_tg_pkg::*;
#(
    parameter int ADDR_W = TG_ADDR_W,
    parameter int ID_W   = TG_ID_W,
    parameter int TS_W   = TG_TS_W,
    parameter int CNT_W  = TG_CNT_W,
    parameter int LSUM_W = TG_LSUM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_num_txn,
    input  logic [15:0]       cfg_rate_period,
    input  logic [7:0]        cfg_burst,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic              cfg_is_wr,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [ID_W-1:0]   req_id,
    output logic              req_is_wr,
    input  logic              rsp_valid,
    input  logic [ID_W-1:0]   rsp_id,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  stat_issued,
    output logic [CNT_W-1:0]  stat_completed,
    output logic [LSUM_W-1:0] stat_lat_sum,
    output logic [TS_W-1:0]   stat_lat_max,
    output logic              err_unexp_rsp
);

    localparam int NUM_IDS = 1 << ID_W;

    tg_state_e           state_q, state_d;
    logic [CNT_W-1:0]    num_q, issued_q, completed_q;
    logic [15:0]         period_q;
    logic [7:0]          burst_q;
    logic [ADDR_W-1:0]   stride_q, addr_q, req_addr_q;
    logic                is_wr_q, req_valid_q, err_q;
    logic [ID_W-1:0]     req_id_q;
    logic [LSUM_W-1:0]   lat_sum_q;
    logic [TS_W-1:0]     lat_max_q, ts_q, lat;
    logic [NUM_IDS-1:0]  busy_q, busy_d;
    logic [TS_W-1:0]     ts_tab_q [NUM_IDS];
    logic                start, hs, rsp_hit, launch, tok_avail;

    assign start   = cfg_start && ((state_q == IDLE) || (state_q == DONE));
    assign hs      = req_valid_q && req_ready;
    assign rsp_hit = rsp_valid && busy_q[rsp_id];
    assign lat     = ts_q - ts_tab_q[rsp_id];
    // Holding off while valid is up keeps req_* stable and gives at most one request per two cycles.
    assign launch  = (state_q == RUN) && !req_valid_q && (issued_q < num_q)
                   && ((period_q == 16'd0) || tok_avail) && !busy_q[issued_q[ID_W-1:0]];

    newperf_token_bucket u_bucket (
        .clk     (clk),
        .reset   (reset),
        .en      (state_q == RUN),
        .load    (start),
        .period  (start ? cfg_rate_period : period_q),
        .depth   (start ? cfg_burst : burst_q),
        .consume (hs),
        .avail   (tok_avail)
    );

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE, DONE: if (cfg_start) state_d = (cfg_num_txn == '0) ? DONE : RUN;
            RUN:        if (hs && (issued_q + CNT_W'(1) == num_q)) state_d = DRAIN;
            DRAIN:      if (completed_q == issued_q) state_d = DONE;
            default:    state_d = IDLE;
        endcase
        if ((state_q == RUN) || (state_q == DRAIN)) busy = 1'b1;
        if (state_q == DONE) done = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        busy_d = busy_q;
        if (rsp_hit) busy_d[rsp_id]   = 1'b0;
        if (hs)      busy_d[req_id_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_q <= '0; period_q <= '0; burst_q <= '0; stride_q <= '0; is_wr_q <= 1'b0;
            addr_q <= '0; issued_q <= '0; completed_q <= '0; lat_sum_q <= '0; lat_max_q <= '0;
            err_q <= 1'b0; busy_q <= '0; ts_q <= '0;
            req_valid_q <= 1'b0; req_addr_q <= '0; req_id_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (start) begin
                num_q <= cfg_num_txn; period_q <= cfg_rate_period; burst_q <= cfg_burst;
                stride_q <= cfg_stride; is_wr_q <= cfg_is_wr; addr_q <= cfg_base_addr;
                issued_q <= '0; completed_q <= '0; lat_sum_q <= '0; lat_max_q <= '0;
                err_q <= 1'b0; busy_q <= '0; req_valid_q <= 1'b0;
            end else begin
                if (launch) begin
                    req_valid_q <= 1'b1;
                    req_addr_q  <= addr_q;
                    req_id_q    <= issued_q[ID_W-1:0];
                    addr_q      <= addr_q + stride_q;
                end else if (hs) begin
                    req_valid_q <= 1'b0;
                end
                if (hs) issued_q <= issued_q + CNT_W'(1);
                if (rsp_hit) begin
                    completed_q <= completed_q + CNT_W'(1);
                    lat_sum_q   <= LSUM_W'(lat_sat_add(TG_LSUM_W'(lat_sum_q), TG_LSUM_W'(lat)));
                    if (lat > lat_max_q) lat_max_q <= lat;
                end else if (rsp_valid) begin
                    err_q <= 1'b1;
                end
                busy_q <= busy_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) ts_tab_q[req_id_q] <= ts_q;
    end

    assign req_valid      = req_valid_q;
    assign req_addr       = req_addr_q;
    assign req_id         = req_id_q;
    assign req_is_wr      = is_wr_q;
    assign stat_issued    = issued_q;
    assign stat_completed = completed_q;
    assign stat_lat_sum   = lat_sum_q;
    assign stat_lat_max   = lat_max_q;
    assign err_unexp_rsp  = err_q;

endmodule
